// File: rtl/sub_result_bcd_pkg.sv
// -----------------------------------------------------------------------------
// sub_bcd_pkg
// Shared types and constants for the signed-difference to BCD converter.
//   state_t          : converter FSM states (IDLE, SHIFT)
//   WIDTH_DEF        : default width of the difference input
//   DIGITS_DEF       : default number of BCD output digits
//   BCD_CORR_THRESH  : a nibble at or above this value is corrected before a shift
//   BCD_CORR_ADD     : amount added to a nibble that needs correction
//   clog2()          : bits needed to count 0..n-1
// -----------------------------------------------------------------------------
package sub_bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEF  = 8;
    localparam int DIGITS_DEF = 3;

    localparam logic [3:0] BCD_CORR_THRESH = 4'd5;
    localparam logic [3:0] BCD_CORR_ADD    = 4'd3;

    // Number of bits needed to hold values 0..n-1 (at least 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_result_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_dabble_digit
// Shift-add-3 correction for one BCD nibble: values 5..9 get +3 so that the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   digit     : input  [3:0]  nibble before correction
//   corrected : output [3:0]  nibble after correction
// -----------------------------------------------------------------------------
module bcd_dabble_digit
    import sub_bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    always_comb begin
        corrected = digit;
        if (digit >= BCD_CORR_THRESH) begin
            corrected = digit + BCD_CORR_ADD;
        end
    end

endmodule

// File: rtl/sub_result_bcd.sv
// -----------------------------------------------------------------------------
// sub_result_bcd
// Converts the subtractor result {bout, d} (9-bit two's complement for
// WIDTH=8) into sign + BCD digits by double dabble, one magnitude bit per clock.
// Ports:
//   clk       : input            system clock, rising edge
//   rst_n     : input            asynchronous active-low reset
//   d         : input  [WIDTH-1] difference value
//   bout      : input            borrow-out, 1 = negative result
//   in_valid  : input            d/bout valid this cycle
//   in_ready  : output           idle, accepts on in_valid
//   out_valid : output           one-cycle pulse, new sign/bcd
//   sign      : output           1 = negative result
//   bcd       : output [4*DIGITS-1:0] digits, [3:0] = ones
//   busy      : output           conversion in progress
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE (including the out_valid cycle), so a new
// value may be accepted on the same edge that follows the result pulse.
// -----------------------------------------------------------------------------
module sub_result_bcd
    import sub_bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    d,
    input  logic                bout,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    output logic                sign,
    output logic [4*DIGITS-1:0] bcd,
    output logic                busy
);

    localparam int MW = WIDTH + 1;           // magnitude width
    localparam int BW = 4 * DIGITS;          // BCD field width
    localparam int SW = BW + MW;             // shift register width
    localparam int CW = clog2(WIDTH + 1);    // counts 0..WIDTH

    localparam logic [MW-1:0] TWO_W = {1'b1, {WIDTH{1'b0}}};
    localparam logic [CW-1:0] LAST  = CW'(WIDTH);

    state_t         state, state_next;
    logic [SW-1:0]  sr, sr_next;             // {bcd field, magnitude}
    logic [CW-1:0]  cnt, cnt_next;
    logic           sign_hold, sign_hold_next;
    logic           out_valid_next;
    logic           sign_next;
    logic [BW-1:0]  bcd_next;

    logic [MW-1:0]  mag_in;
    logic [BW-1:0]  corr_bcd;
    logic [SW-1:0]  sr_shifted;

    // Magnitude of the signed result; d=0 with bout=1 yields 2^WIDTH.
    assign mag_in = bout ? (TWO_W - {1'b0, d}) : {1'b0, d};

    // Correction applies to the BCD field only, never to unconverted bits.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_dabble_digit u_digit (
            .digit     (sr[MW + 4*g +: 4]),
            .corrected (corr_bcd[4*g +: 4])
        );
    end

    // The top bit shifted out is always zero given 10^DIGITS > 2^WIDTH.
    assign sr_shifted = {corr_bcd, sr[MW-1:0]} << 1;

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;

    always_comb begin
        state_next     = state;
        sr_next        = sr;
        cnt_next       = cnt;
        sign_hold_next = sign_hold;
        out_valid_next = 1'b0;
        sign_next      = sign;
        bcd_next       = bcd;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sr_next        = {{BW{1'b0}}, mag_in};
                    sign_hold_next = bout;
                    cnt_next       = '0;
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                sr_next  = sr_shifted;
                cnt_next = cnt + CW'(1);
                if (cnt == LAST) begin
                    cnt_next       = '0;
                    state_next     = IDLE;
                    out_valid_next = 1'b1;
                    sign_next      = sign_hold;
                    bcd_next       = sr_shifted[SW-1 -: BW];
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            sign_hold <= 1'b0;
            out_valid <= 1'b0;
            sign      <= 1'b0;
            bcd       <= '0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            cnt       <= cnt_next;
            sign_hold <= sign_hold_next;
            out_valid <= out_valid_next;
            sign      <= sign_next;
            bcd       <= bcd_next;
        end
    end

endmodule
